mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester (I$/D$) arbiter driving one line-based memory
//               port with command, write-beat and read-beat phases.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_wnext,
  output logic [31:0] rdata,
  output logic        ic_rvalid,
  output logic        dc_rvalid,
  output logic        ic_done,
  output logic        dc_done,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_we,
  output logic [27:0] mem_cmd_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(BEATS == 2 || BEATS == 4 || BEATS == 8)) begin : g_beats_check
    $error("mem_arbiter: BEATS must be 2, 4 or 8");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_gnt_dc;   // 1 = D$ owns the current transaction
  logic            r_last_dc;  // 1 = D$ was granted last
  logic            r_we;
  logic [27:0]     r_addr;
  logic [CW-1:0]   r_cnt;
  logic            w_grant_dc;
  logic            w_start;
  logic            w_last_beat;
  logic            w_beat;
  logic            w_unused;

  assign w_unused = ^{ic_addr[3:0], dc_addr[3:0]};

  // On a tie the requester that was not granted last wins.
  assign w_grant_dc  = dc_req && (!ic_req || !r_last_dc);
  assign w_start     = (r_state == S_IDLE) && (ic_req || dc_req);
  assign w_last_beat = (r_cnt == CW'(BEATS - 1));
  assign w_beat      = ((r_state == S_WRITE) && mem_wready) ||
                       ((r_state == S_READ)  && mem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt_dc  <= 1'b0;
      r_last_dc <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 28'd0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_gnt_dc <= w_grant_dc;
        r_we     <= w_grant_dc && dc_we;
        r_addr   <= w_grant_dc ? dc_addr[31:4] : ic_addr[31:4];
        r_cnt    <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_DONE) begin
        r_last_dc <= r_gnt_dc;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    dc_wnext      = 1'b0;
    rdata         = 32'd0;
    ic_rvalid     = 1'b0;
    dc_rvalid     = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = 28'd0;
    mem_wdata     = 32'd0;
    mem_wvalid    = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (ic_req || dc_req) w_next = S_CMD;
      end
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = r_we;
        mem_cmd_addr  = r_addr;
        if (mem_cmd_ready) w_next = r_we ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        mem_wvalid = 1'b1;
        mem_wdata  = dc_wdata;
        dc_wnext   = mem_wready && r_gnt_dc;
        if (mem_wready && w_last_beat) w_next = S_DONE;
      end
      S_READ: begin
        rdata     = mem_rdata;
        ic_rvalid = mem_rvalid && !r_gnt_dc;
        dc_rvalid = mem_rvalid &&  r_gnt_dc;
        if (mem_rvalid && w_last_beat) w_next = S_DONE;
      end
      S_DONE: begin
        ic_done = !r_gnt_dc;
        dc_done =  r_gnt_dc;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench with a cycle-level memory model.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'd0;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = 32'd0;
  logic [31:0] dc_wdata = 32'd0;
  logic        dc_wnext;
  logic [31:0] rdata;
  logic        ic_rvalid, dc_rvalid, ic_done, dc_done;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b0;
  logic        mem_cmd_we;
  logic [27:0] mem_cmd_addr;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .rdata(rdata),
    .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .ic_done(ic_done), .dc_done(dc_done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Serves one transaction for the requester 'dc' whose req the caller has
  // just raised. Returns the cycle index (0 = first IDLE cycle) of the done pulse.
  task automatic serve(input bit dc, input bit we, input logic [31:0] addr,
                       input int rdy_delay, input logic [7:0] pat,
                       input logic [31:0] dbase, input bit drop_req,
                       input bit chg_addr, input int abort_at,
                       output int done_cyc);
    int          phase = 0;
    int          beat  = 0;
    int          pi    = 0;
    int          vcnt  = 0;
    int          n     = 0;
    bit          drv_v = 1'b0;
    bit          fin   = 1'b0;
    logic        rv_me, rv_other, dn_me, dn_other;
    logic [31:0] cur = 32'd0;
    logic [31:0] exp;
    done_cyc      = -1;
    mem_cmd_ready = (rdy_delay == 0);
    mem_rvalid    = 1'b1;
    mem_wready    = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    while (!fin && n < 40) begin
      @(negedge clk);
      n++;
      rv_me    = dc ? dc_rvalid : ic_rvalid;
      rv_other = dc ? ic_rvalid : dc_rvalid;
      dn_me    = dc ? dc_done   : ic_done;
      dn_other = dc ? ic_done   : dc_done;
      if (phase == 1 && !we && drv_v) begin
        exp = sb.pop_front();
        check("rvalid_granted", rv_me, 1);
        check("rvalid_other", rv_other, 0);
        check("rdata", rdata, exp);
      end else begin
        check("rvalid_quiet", {ic_rvalid, dc_rvalid}, 0);
      end
      if (phase == 1 && we) begin
        check("wvalid", mem_wvalid, 1);
        check("wdata", mem_wdata, cur);
        check("wnext", dc_wnext, drv_v);
      end else begin
        check("wnext_quiet", dc_wnext, 0);
      end
      if (phase == 2) begin
        check("done_granted", dn_me, 1);
        check("done_other", dn_other, 0);
        done_cyc = n - 1;
        fin = 1'b1;
      end else begin
        check("done_quiet", {ic_done, dc_done}, 0);
      end
      if (phase == 0) begin
        if (mem_cmd_valid) begin
          check("cmd_addr", mem_cmd_addr, addr[31:4]);
          check("cmd_we", mem_cmd_we, we);
          if (mem_cmd_ready) phase = 1;
          else vcnt++;
        end
      end else if (phase == 1) begin
        check("busy", busy, 1);
        if (drv_v) beat++;
        if (abort_at > 0 && beat == abort_at) begin
          #1 rst = 1'b1;
          #1;
          check("rst_busy", busy, 0);
          check("rst_cmd_valid", mem_cmd_valid, 0);
          check("rst_rvalid", {ic_rvalid, dc_rvalid}, 0);
          check("rst_rdata", rdata, 0);
          check("rst_done", {ic_done, dc_done}, 0);
          @(posedge clk); #1;
          ic_req = 1'b0; dc_req = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {ic_done, dc_done}, 0);
            check("abort_idle", busy, 0);
          end
          sb.delete();
          fin = 1'b1;
          break;
        end
        if (beat == BEATS) phase = 2;
      end
      @(posedge clk); #1;
      drv_v = 1'b0;
      if (fin) begin
        if (dc) begin dc_req = 1'b0; dc_we = 1'b0; end
        else ic_req = 1'b0;
      end else if (phase == 0) begin
        mem_cmd_ready = (vcnt >= rdy_delay);
        if (chg_addr && dc && vcnt > 0) begin
          dc_addr = addr ^ 32'hFFFF_FFF0;
          dc_we   = ~we;
        end
      end else if (phase == 1) begin
        mem_cmd_ready = 1'b0;
        if (drop_req) begin
          if (dc) dc_req = 1'b0; else ic_req = 1'b0;
        end
        drv_v = pat[pi % 8];
        pi++;
        if (we) begin
          mem_wready = drv_v;
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0_0000 + pi;
          cur        = dbase + beat;
          dc_wdata   = cur;
        end else begin
          mem_rvalid = drv_v;
          mem_wready = 1'b1;
          mem_rdata  = drv_v ? dbase + beat : 32'hBAD0_0000 + pi;
          if (drv_v) sb.push_back(dbase + beat);
        end
      end else begin
        mem_rvalid = 1'b1;
        mem_wready = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
    end
    check("serve_complete", fin, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_cmd_valid", mem_cmd_valid, 0);
    check("reset_cmd_addr", mem_cmd_addr, 0);
    check("reset_rvalid", {ic_rvalid, dc_rvalid}, 0);
    check("reset_done", {ic_done, dc_done}, 0);
    check("reset_wvalid", mem_wvalid, 0);
    check("reset_wnext", dc_wnext, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain I$ fill: data 1..4, done six cycles after the request.
    @(posedge clk); #1;
    ic_addr = 32'h1000_0040; ic_req = 1'b1;
    serve(1'b0, 1'b0, 32'h1000_0040, 0, 8'hFF, 32'd1, 1'b0, 1'b0, 0, dcyc);
    check("ic_fill_latency", dcyc, 6);

    // Ties after reset: D$ first, then I$; next tie again D$.
    do_reset();
    ic_addr = 32'h2000_0100; dc_addr = 32'h3000_0200; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    serve(1'b1, 1'b0, 32'h3000_0200, 0, 8'hFF, 32'h100, 1'b0, 1'b0, 0, dcyc);
    serve(1'b0, 1'b0, 32'h2000_0100, 0, 8'hFF, 32'h200, 1'b0, 1'b0, 0, dcyc);
    ic_addr = 32'h2100_0000; dc_addr = 32'h3100_0010;
    ic_req = 1'b1; dc_req = 1'b1;
    serve(1'b1, 1'b0, 32'h3100_0010, 0, 8'hFF, 32'h300, 1'b0, 1'b0, 0, dcyc);
    serve(1'b0, 1'b0, 32'h2100_0000, 0, 8'hFF, 32'h400, 1'b0, 1'b0, 0, dcyc);

    // After a lone D$ grant, a tie goes to I$.
    dc_addr = 32'h3200_0020; dc_req = 1'b1;
    serve(1'b1, 1'b0, 32'h3200_0020, 0, 8'hFF, 32'h500, 1'b0, 1'b0, 0, dcyc);
    ic_addr = 32'h2200_0030; dc_addr = 32'h3300_0040;
    ic_req = 1'b1; dc_req = 1'b1;
    serve(1'b0, 1'b0, 32'h2200_0030, 0, 8'hFF, 32'h600, 1'b0, 1'b0, 0, dcyc);
    serve(1'b1, 1'b0, 32'h3300_0040, 0, 8'hFF, 32'h700, 1'b0, 1'b0, 0, dcyc);

    // D$ writeback with wready 1,0,1,1,0,1.
    dc_addr = 32'h4000_0000; dc_we = 1'b1; dc_req = 1'b1;
    serve(1'b1, 1'b1, 32'h4000_0000, 0, 8'b0010_1101, 32'hA000, 1'b0, 1'b0, 0, dcyc);

    // Command stalled five cycles while the D$ address and we change.
    dc_addr = 32'h5000_0030; dc_we = 1'b0; dc_req = 1'b1;
    serve(1'b1, 1'b0, 32'h5000_0030, 5, 8'hFF, 32'hB000, 1'b0, 1'b1, 0, dcyc);

    // I$ fill with gapped rvalid and req dropped mid-transaction.
    ic_addr = 32'h6000_0050; ic_req = 1'b1;
    serve(1'b0, 1'b0, 32'h6000_0050, 1, 8'b1011_0101, 32'hC000, 1'b1, 1'b0, 0, dcyc);

    // Reset mid-read after two beats, then a clean fill.
    ic_addr = 32'h7000_0060; ic_req = 1'b1;
    serve(1'b0, 1'b0, 32'h7000_0060, 0, 8'hFF, 32'hD000, 1'b0, 1'b0, 2, dcyc);
    @(posedge clk); #1;
    ic_addr = 32'h7100_0070; ic_req = 1'b1;
    serve(1'b0, 1'b0, 32'h7100_0070, 0, 8'hFF, 32'hE000, 1'b0, 1'b0, 0, dcyc);
    check("ic_refill_latency", dcyc, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
